// File: rtl/ssd1306_spi_pkg.sv
// rtl/ssd1306_spi_pkg.sv - shared types and constants for the SSD1306 SPI transmitter
package ssd1306_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } spi_state_t;

    localparam int   SPI_BITS  = 8;
    localparam logic SCLK_IDLE = 1'b1;

endpackage

// File: rtl/ssd1306_spi_tx_if.sv
// rtl/ssd1306_spi_tx_if.sv - executor-to-transmitter byte handshake
interface ssd1306_spi_tx_if;

    logic       tx_trigger_in;
    logic [7:0] data_in;
    logic       last_byte_in;
    logic       ready_out;

    modport master (
        output tx_trigger_in,
        output data_in,
        output last_byte_in,
        input  ready_out
    );

    modport slave (
        input  tx_trigger_in,
        input  data_in,
        input  last_byte_in,
        output ready_out
    );

endinterface

// File: rtl/ssd1306_spi_tick_gen.sv
// rtl/ssd1306_spi_tick_gen.sv - CLK_DIV down-counter emitting a tick on each half-period boundary
module ssd1306_spi_tick_gen #(
    parameter int CLK_DIV  = 2,
    parameter int CNT_BITS = $clog2(CLK_DIV + 1)
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic restart_in,
    output logic tick_out
);

    localparam logic [CNT_BITS-1:0] RELOAD = CNT_BITS'(CLK_DIV - 1);

    logic [CNT_BITS-1:0] cnt_q;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt_q <= '0;
        end else if (restart_in || (cnt_q == '0)) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CNT_BITS'(1);
        end
    end

    assign tick_out = (cnt_q == '0);

endmodule

// File: rtl/ssd1306_spi_tx.sv
// rtl/ssd1306_spi_tx.sv - SPI mode-3 byte transmitter owning CS# framing for the SSD1306
module ssd1306_spi_tx
    import ssd1306_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              clk_in,
    input  logic              reset_in,
    ssd1306_spi_tx_if.slave   tx,
    output logic              spi_sclk_out,
    output logic              spi_mosi_out,
    output logic              spi_csn_out
);

    localparam int         CNT_BITS = $clog2(CLK_DIV + 1);
    localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("ssd1306_spi_tx: CLK_DIV must be at least 1");
    end

    spi_state_t state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       csn_q, csn_d;
    logic       ready_q, ready_d;
    logic [2:0] next_bit;
    logic       tick;

    // Divider is held in reload while idle so every phase starts a full CLK_DIV.
    ssd1306_spi_tick_gen #(
        .CLK_DIV  (CLK_DIV),
        .CNT_BITS (CNT_BITS)
    ) u_tick_gen (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .restart_in (state_q == IDLE),
        .tick_out   (tick)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            data_q    <= '0;
            last_q    <= 1'b0;
            bit_cnt_q <= '0;
            sclk_q    <= SCLK_IDLE;
            mosi_q    <= 1'b0;
            csn_q     <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            csn_q     <= csn_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        csn_d     = csn_q;
        ready_d   = ready_q;
        next_bit  = bit_cnt_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (tx.tx_trigger_in && ready_q) begin
                    data_d    = tx.data_in;
                    last_d    = tx.last_byte_in;
                    ready_d   = 1'b0;
                    bit_cnt_d = '0;
                    mosi_d    = tx.data_in[SPI_BITS-1];
                    if (csn_q) begin
                        state_d = CS_SETUP;
                        csn_d   = 1'b0;
                        sclk_d  = SCLK_IDLE;
                    end else begin
                        // Frame continuation: the first falling edge is this accept edge.
                        state_d = SHIFT;
                        sclk_d  = ~SCLK_IDLE;
                    end
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = ~SCLK_IDLE;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q != SCLK_IDLE) begin
                        sclk_d = SCLK_IDLE;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (last_q) begin
                            state_d = CS_HOLD;
                        end else begin
                            state_d = IDLE;
                            ready_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = next_bit;
                        sclk_d    = ~SCLK_IDLE;
                        mosi_d    = data_q[~next_bit];
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    state_d = CS_GAP;
                    csn_d   = 1'b1;
                end
            end
            CS_GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                csn_d   = 1'b1;
                sclk_d  = SCLK_IDLE;
            end
        endcase
    end

    assign tx.ready_out  = ready_q;
    assign spi_sclk_out  = sclk_q;
    assign spi_mosi_out  = mosi_q;
    assign spi_csn_out   = csn_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// tb/tb_ssd1306_spi_tx.sv - directed bench for ssd1306_spi_tx at CLK_DIV=2 and CLK_DIV=1
module tb_ssd1306_spi_tx;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       trig_a = 1'b0;
    logic       trig_b = 1'b0;
    logic [7:0] data_s = 8'h00;
    logic       last_s = 1'b0;

    logic sclk_a, mosi_a, csn_a;
    logic sclk_b, mosi_b, csn_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    ssd1306_spi_tx_if ifa ();
    ssd1306_spi_tx_if ifb ();

    assign ifa.tx_trigger_in = trig_a;
    assign ifa.data_in       = data_s;
    assign ifa.last_byte_in  = last_s;
    assign ifb.tx_trigger_in = trig_b;
    assign ifb.data_in       = data_s;
    assign ifb.last_byte_in  = last_s;

    ssd1306_spi_tx #(.CLK_DIV(2)) dut_a (
        .clk_in       (clk_in),
        .reset_in     (rst),
        .tx           (ifa),
        .spi_sclk_out (sclk_a),
        .spi_mosi_out (mosi_a),
        .spi_csn_out  (csn_a)
    );

    ssd1306_spi_tx #(.CLK_DIV(1)) dut_b (
        .clk_in       (clk_in),
        .reset_in     (rst),
        .tx           (ifb),
        .spi_sclk_out (sclk_b),
        .spi_mosi_out (mosi_b),
        .spi_csn_out  (csn_b)
    );

    // Panel models: shift MOSI in on rising SCLK while CS# is low.
    logic [7:0] rx_a[$];
    logic [7:0] rx_b[$];
    logic [7:0] sh_a = 8'h00, sh_b = 8'h00;
    int nb_a = 0, nb_b = 0;
    int win_a = 0, win_b = 0;
    int per_min_a = 1000, per_max_a = 0, per_min_b = 1000, per_max_b = 0;
    time last_rise_a = 0, last_rise_b = 0;
    int viol_a = 0, viol_b = 0;
    bit ps_a = 1'b1, pm_a = 1'b0, ps_b = 1'b1, pm_b = 1'b0;

    always @(posedge sclk_a) begin
        if (csn_a === 1'b0) begin
            if (nb_a != 0) begin
                per_min_a = (int'(($time - last_rise_a) / 10) < per_min_a) ? int'(($time - last_rise_a) / 10) : per_min_a;
                per_max_a = (int'(($time - last_rise_a) / 10) > per_max_a) ? int'(($time - last_rise_a) / 10) : per_max_a;
            end
            last_rise_a = $time;
            sh_a = {sh_a[6:0], mosi_a};
            nb_a++;
            if (nb_a == 8) begin
                rx_a.push_back(sh_a);
                nb_a = 0;
            end
        end
    end
    always @(posedge csn_a) nb_a = 0;
    always @(negedge csn_a) win_a++;

    always @(posedge sclk_b) begin
        if (csn_b === 1'b0) begin
            if (nb_b != 0) begin
                per_min_b = (int'(($time - last_rise_b) / 10) < per_min_b) ? int'(($time - last_rise_b) / 10) : per_min_b;
                per_max_b = (int'(($time - last_rise_b) / 10) > per_max_b) ? int'(($time - last_rise_b) / 10) : per_max_b;
            end
            last_rise_b = $time;
            sh_b = {sh_b[6:0], mosi_b};
            nb_b++;
            if (nb_b == 8) begin
                rx_b.push_back(sh_b);
                nb_b = 0;
            end
        end
    end
    always @(posedge csn_b) nb_b = 0;
    always @(negedge csn_b) win_b++;

    // A MOSI change in the same cycle as an SCLK rise is a mode-3 violation.
    always @(negedge clk_in) begin
        if (!ps_a && sclk_a === 1'b1 && mosi_a !== pm_a) viol_a++;
        if (!ps_b && sclk_b === 1'b1 && mosi_b !== pm_b) viol_b++;
        ps_a = sclk_a; pm_a = mosi_a;
        ps_b = sclk_b; pm_b = mosi_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? ifa.ready_out : ifb.ready_out;
    endfunction

    function automatic logic csn_of(input int w);
        return (w == 0) ? csn_a : csn_b;
    endfunction

    task automatic set_trig(input int w, input logic v);
        if (w == 0) trig_a = v;
        else        trig_b = v;
    endtask

    task automatic wait_ready(input int w);
        for (int t = 0; t < 400 && rdy(w) !== 1'b1; t++) @(negedge clk_in);
        check("ready_before_send", rdy(w), 1'b1);
    endtask

    // Trigger stays high for the accept edge plus one, as the executor does.
    task automatic send(input int w, input logic [7:0] b, input logic l, output int low, output int gap);
        wait_ready(w);
        data_s = b;
        last_s = l;
        set_trig(w, 1'b1);
        @(posedge clk_in);
        @(negedge clk_in);
        low = 0;
        gap = 0;
        for (int t = 0; t < 400 && rdy(w) !== 1'b1; t++) begin
            low++;
            if (csn_of(w) === 1'b1) gap++;
            @(negedge clk_in);
            if (t == 0) set_trig(w, 1'b0);
        end
        set_trig(w, 1'b0);
        check("ready_return", rdy(w), 1'b1);
    endtask

    initial begin
        int low, gap, n0, w0;
        logic [7:0] hold_bytes [3];
        hold_bytes[0] = 8'h00;
        hold_bytes[1] = 8'hFF;
        hold_bytes[2] = 8'h81;

        #12;
        check("rst_ready", ifa.ready_out, 1'b1);
        check("rst_sclk", sclk_a, 1'b1);
        check("rst_mosi", mosi_a, 1'b0);
        check("rst_csn", csn_a, 1'b1);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);

        // Single framed byte 0xA5
        send(0, 8'hA5, 1'b1, low, gap);
        check("a5_low", low, 38);
        check("a5_csn_gap", gap, 2);
        check("a5_rx_count", rx_a.size(), 1);
        check("a5_rx", rx_a[0], 8'hA5);
        check("a5_windows", win_a, 1);
        check("a5_period_min", per_min_a, 4);
        check("a5_period_max", per_max_a, 4);

        // Two-byte frame in one CS# window
        send(0, 8'hAE, 1'b0, low, gap);
        check("ae_low", low, 34);
        check("ae_csn_gap", gap, 0);
        check("ae_csn_held", csn_a, 1'b0);
        repeat (5) @(negedge clk_in);
        check("ae_idle_csn", csn_a, 1'b0);
        check("ae_idle_sclk", sclk_a, 1'b1);
        send(0, 8'h8D, 1'b1, low, gap);
        check("8d_low", low, 36);
        check("8d_csn_gap", gap, 2);
        check("frame_rx_count", rx_a.size(), 3);
        check("frame_rx0", rx_a[1], 8'hAE);
        check("frame_rx1", rx_a[2], 8'h8D);
        check("frame_windows", win_a, 2);

        // Trigger held high across three last-byte transfers
        n0 = rx_a.size();
        w0 = win_a;
        last_s = 1'b1;
        trig_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_s = hold_bytes[k];
            for (int t = 0; t < 400 && ifa.ready_out !== 1'b1; t++) @(negedge clk_in);
            @(posedge clk_in);
            @(negedge clk_in);
        end
        trig_a = 1'b0;
        wait_ready(0);
        check("hold_rx_count", rx_a.size() - n0, 3);
        check("hold_rx0", rx_a[n0], 8'h00);
        check("hold_rx1", rx_a[n0+1], 8'hFF);
        check("hold_rx2", rx_a[n0+2], 8'h81);
        check("hold_windows", win_a - w0, 3);

        // Asynchronous reset in the middle of SHIFT
        wait_ready(0);
        data_s = 8'h5A;
        last_s = 1'b1;
        trig_a = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        trig_a = 1'b0;
        repeat (8) @(negedge clk_in);
        check("pre_rst_csn", csn_a, 1'b0);
        n0 = rx_a.size();
        @(posedge clk_in);
        #3 rst = 1'b1;
        #1;
        check("async_csn", csn_a, 1'b1);
        check("async_sclk", sclk_a, 1'b1);
        check("async_ready", ifa.ready_out, 1'b1);
        rst = 1'b0;
        send(0, 8'h3C, 1'b1, low, gap);
        check("post_rst_low", low, 38);
        check("post_rst_rx_count", rx_a.size() - n0, 1);
        check("post_rst_rx", rx_a[rx_a.size()-1], 8'h3C);
        check("a_mosi_on_rise", viol_a, 0);

        // CLK_DIV=1 instance
        send(1, 8'h55, 1'b1, low, gap);
        check("div1_low", low, 19);
        check("div1_csn_gap", gap, 1);
        check("div1_rx_count", rx_b.size(), 1);
        check("div1_rx", rx_b[0], 8'h55);
        check("div1_period_min", per_min_b, 2);
        check("div1_period_max", per_max_b, 2);
        check("div1_mosi_on_rise", viol_b, 0);
        check("div1_windows", win_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
